// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state codes,
// default geometry and latency, and byte-lane mask helpers.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_RD_LAT_DEF = 2;
    localparam int DMEM_ADDR_W_DEF = 10;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        WRITE_ENABLE = 1'b1;

    localparam logic [7:0] LANE_ON  = 8'hFF;
    localparam logic [7:0] LANE_OFF = 8'h00;

    // sel[3] enables data[31:24] (byte 0 in big-endian order)
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        lane_mask = {sel[3] ? LANE_ON : LANE_OFF,
                     sel[2] ? LANE_ON : LANE_OFF,
                     sel[1] ? LANE_ON : LANE_OFF,
                     sel[0] ? LANE_ON : LANE_OFF};
    endfunction

endpackage

// File: rtl/dmem_responder_byte_ram.sv
// Word array with four independent byte-lane write enables and an
// asynchronous read port. Contents are deliberately not reset.
module dmem_byte_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [31:0]       wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: fixed-latency reads with pipeline stall,
// posted writes through a one-entry buffer with read forwarding.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   DMEM_IDLE | no read in flight; an in-range read stalls and starts here
//   DMEM_WAIT | counting read wait states; abort if the request changes
//   DMEM_RESP | read word valid on mem_data_o, stall released
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          ADDR_W  = DMEM_ADDR_W_DEF,
    parameter int          RD_LAT  = DMEM_RD_LAT_DEF,
    parameter logic [31:0] BASE_HI = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq_o,
    output logic        addr_err_o
);

    localparam int HI_W = 30 - ADDR_W;

    dmem_state_e       state_q;
    logic [3:0]        cnt_q;
    logic [29:0]       req_addr_q;
    logic              wb_valid_q;
    logic [ADDR_W-1:0] wb_idx_q;
    logic [3:0]        wb_sel_q;
    logic [31:0]       wb_data_q;
    logic [31:0]       data_q;
    logic              err_q;

    logic [HI_W-1:0]   base_cmp;
    logic              in_rng;
    logic [ADDR_W-1:0] idx;
    logic              rd_req;
    logic              wr_req;
    logic              abort;
    logic [31:0]       ram_rdata;
    logic [3:0]        ram_we;
    logic              fwd_hit;
    logic [31:0]       fwd_mask;
    logic [31:0]       rd_word_d;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^mem_addr_i[1:0];

    assign base_cmp = BASE_HI[HI_W-1:0];
    assign in_rng   = (mem_addr_i[31:ADDR_W+2] == base_cmp);
    assign idx      = mem_addr_i[ADDR_W+1:2];
    assign rd_req   = mem_ce_i & ~mem_we_i & in_rng;
    assign wr_req   = mem_ce_i &  mem_we_i & in_rng;

    // The latched request is always a read, so any write strobe is a change too
    assign abort = ~mem_ce_i | mem_we_i | (mem_addr_i[31:2] != req_addr_q);

    assign ram_we = (wb_valid_q == WRITE_ENABLE) ? wb_sel_q : 4'b0000;

    dmem_byte_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wb_idx_q),
        .wdata_i (wb_data_q),
        .raddr_i (idx),
        .rdata_o (ram_rdata)
    );

    // The buffer commits on the same edge that captures, so merge its lanes in
    assign fwd_hit   = wb_valid_q & (wb_idx_q == idx);
    assign fwd_mask  = lane_mask(wb_sel_q);
    assign rd_word_d = fwd_hit ? ((ram_rdata & ~fwd_mask) | (wb_data_q & fwd_mask))
                               : ram_rdata;

    always_comb begin
        stallreq_o = 1'b0;
        case (state_q)
            DMEM_IDLE: stallreq_o = rd_req;
            DMEM_WAIT: stallreq_o = ~abort;
            default:   stallreq_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= DMEM_IDLE;
            cnt_q      <= 4'd0;
            req_addr_q <= '0;
            wb_valid_q <= 1'b0;
            wb_idx_q   <= '0;
            wb_sel_q   <= 4'b0000;
            wb_data_q  <= ZERO_WORD;
            data_q     <= ZERO_WORD;
            err_q      <= 1'b0;
        end else begin
            err_q      <= mem_ce_i & ~in_rng;
            wb_valid_q <= 1'b0;
            if (wr_req && state_q == DMEM_IDLE) begin
                wb_valid_q <= 1'b1;
                wb_idx_q   <= idx;
                wb_sel_q   <= mem_sel_i;
                wb_data_q  <= mem_data_i;
            end

            case (state_q)
                DMEM_IDLE: begin
                    if (rd_req) begin
                        req_addr_q <= mem_addr_i[31:2];
                        if (RD_LAT == 1) begin
                            state_q <= DMEM_RESP;
                            data_q  <= rd_word_d;
                        end else begin
                            state_q <= DMEM_WAIT;
                            cnt_q   <= 4'(RD_LAT - 1);
                        end
                    end
                end
                DMEM_WAIT: begin
                    if (abort) begin
                        state_q <= DMEM_IDLE;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= DMEM_RESP;
                        data_q  <= rd_word_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DMEM_RESP: state_q <= DMEM_IDLE;
                default:   state_q <= DMEM_IDLE;
            endcase
        end
    end

    assign mem_data_o = data_q;
    assign addr_err_o = err_q;

endmodule
